// File: rtl/isram_arb.sv
// Two-port arbiter (fetch, loader) in front of a single-ported instruction SRAM.
// Define ISRAM_ARB_FAIR_EN to add the loader starvation counter; otherwise fetch has strict priority.
//
// tag state | meaning
// IDLE      | no read response due next cycle
// RD_F      | fetch read granted last cycle, response goes to fetch port
// RD_L      | loader read granted last cycle, response goes to loader port
module isram_arb #(
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        f_req,
  input  logic [63:0] f_addr,
  output logic        f_gnt,
  output logic        f_rvalid,
  output logic [63:0] f_rdata,
  input  logic        l_req,
  input  logic [7:0]  l_we,
  input  logic [63:0] l_addr,
  input  logic [63:0] l_wdata,
  output logic        l_gnt,
  output logic        l_rvalid,
  output logic [63:0] l_rdata,
  output logic        sram_en,
  output logic [7:0]  sram_we,
  output logic [63:0] sram_addr,
  output logic [63:0] sram_wdata,
  input  logic [63:0] sram_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD_F = 2'd1,
    RD_L = 2'd2
  } tag_e;

  tag_e tag_q, tag_d;
  logic force_l;

`ifdef ISRAM_ARB_FAIR_EN
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [3:0] wait_q, wait_d;

  assign force_l = l_req && (wait_q == STARVE_LIM);

  always_comb begin
    wait_d = wait_q;
    if (!l_req || l_gnt) begin
      wait_d = 4'd0;
    end else if (wait_q != STARVE_LIM) begin
      wait_d = wait_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_q <= 4'd0;
    end else begin
      wait_q <= wait_d;
    end
  end
`else
  logic unused_starve;

  assign force_l       = 1'b0;
  assign unused_starve = (STARVE_MAX == 0);
`endif

  // A flushing pipeline must not start a new fetch; the loader is unaffected.
  assign f_gnt = f_req && !flush && !force_l;
  assign l_gnt = l_req && !f_gnt;

  always_comb begin
    sram_en    = 1'b0;
    sram_we    = 8'h00;
    sram_addr  = 64'd0;
    sram_wdata = 64'd0;
    if (f_gnt) begin
      sram_en   = 1'b1;
      sram_addr = f_addr;
    end else if (l_gnt) begin
      sram_en    = 1'b1;
      sram_we    = l_we;
      sram_addr  = l_addr;
      sram_wdata = l_wdata;
    end
    if (!rst_n) begin
      sram_en = 1'b0;
    end
  end

  always_comb begin
    tag_d = IDLE;
    if (f_gnt) begin
      tag_d = RD_F;
    end else if (l_gnt && (l_we == 8'h00)) begin
      tag_d = RD_L;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_q <= IDLE;
    end else begin
      tag_q <= tag_d;
    end
  end

  // Flush in the response cycle drops the fetch data; loader responses always return.
  assign f_rvalid = (tag_q == RD_F) && !flush;
  assign l_rvalid = (tag_q == RD_L);
  assign f_rdata  = f_rvalid ? sram_rdata : 64'd0;
  assign l_rdata  = l_rvalid ? sram_rdata : 64'd0;

endmodule
